rv32_core_sequencer: RTL

Multi-cycle control FSM that drives the rv32im decoder/control unit and the execution datapath. It fetches each instruction over an imem req/ack handshake and presents it to the decoder, then steps execute, memory and writeback using the decoder's control outputs. It updates the PC and raises machine traps. It sits between the bus interfaces and the decoder/ALU/LSU/register file.

---
 rtl/rv32_core_sequencer_pkg.sv | 44 ++++
 rtl/rv32_core_sequencer_if.sv | 24 ++
 rtl/rv32_bus_timeout.sv | 43 ++++
 rtl/rv32_core_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_core_sequencer_pkg.sv
// Shared types for the rv32 multi-cycle sequencer: FSM states, mcause codes,
// latched decoder controls and small PC helpers.
package rv32_core_sequencer_pkg;

  localparam int API_DATA_WIDTH = 32;

  typedef logic [API_DATA_WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } seq_state_e;

  // Machine-mode mcause exception codes raised by the sequencer.
  typedef enum logic [3:0] {
    CAUSE_INSTR_MISALIGNED = 4'd0,
    CAUSE_INSTR_ACCESS     = 4'd1,
    CAUSE_ILLEGAL_INSTR    = 4'd2,
    CAUSE_BREAKPOINT       = 4'd3,
    CAUSE_LOAD_ACCESS      = 4'd5,
    CAUSE_STORE_ACCESS     = 4'd7,
    CAUSE_ECALL_M          = 4'd11
  } trap_cause_e;

  typedef struct packed {
    logic mem_w;
    logic reg_w;
    logic is_lsu;
  } ctrl_t;

  function automatic word_t next_pc(input word_t pc);
    return pc + word_t'(4);
  endfunction

  function automatic logic is_misaligned(input word_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/rv32_core_sequencer_if.sv
// Instruction and data bus handshakes between the sequencer (master) and the
// memory side (slave). Signal suffixes are from the sequencer's point of view.
interface rv32_core_sequencer_if;
  import rv32_core_sequencer_pkg::*;

  logic  imem_req_o;
  word_t imem_addr_o;
  logic  imem_ack_i;
  word_t imem_rdata_i;
  logic  dmem_req_o;
  logic  dmem_we_o;
  logic  dmem_ack_i;

  modport master (
    output imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o,
    input  imem_ack_i, imem_rdata_i, dmem_ack_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, dmem_req_o, dmem_we_o,
    output imem_ack_i, imem_rdata_i, dmem_ack_i
  );

endinterface

// File: rtl/rv32_bus_timeout.sv
// Loadable down-counter that flags a bus access fault after CYCLES waiting
// cycles; CYCLES = 0 disables the expire output.
module rv32_bus_timeout #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic load_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int unsigned LOAD_VAL = (CYCLES == 0) ? 0 : CYCLES - 1;
  localparam int unsigned CNT_W    = (LOAD_VAL > 1) ? $clog2(LOAD_VAL + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(LOAD_VAL);
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter reaches zero in the last allowed waiting cycle.
  assign expired_o = (CYCLES != 0) && count_en_i && (cnt_q == '0);

endmodule

// File: rtl/rv32_core_sequencer.sv
// Multi-cycle control FSM for an rv32im core: fetch, decode, execute, memory,
// writeback and machine traps, with registered Moore strobes.
module rv32_core_sequencer
  import rv32_core_sequencer_pkg::*;
#(
  parameter word_t       RESET_PC       = 32'h0000_0000,
  parameter word_t       TRAP_VECTOR    = 32'h0000_0100,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  rv32_core_sequencer_if.master       bus,
  output word_t                       instr_o,
  input  logic                        illegal_i,
  input  logic                        ecall_i,
  input  logic                        ebreak_i,
  input  logic                        is_lsu_i,
  input  logic                        mem_w_i,
  input  logic                        reg_w_i,
  input  logic                        branch_taken_i,
  input  word_t                       branch_target_i,
  output logic                        ex_en_o,
  output logic                        rf_we_o,
  output word_t                       pc_o,
  output logic                        trap_o,
  output logic [3:0]                  trap_cause_o,
  output word_t                       trap_pc_o
);

  seq_state_e  state_q, state_d;
  word_t       pc_q, pc_d;
  word_t       instr_q, instr_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        br_taken_q, br_taken_d;
  word_t       br_target_q, br_target_d;
  trap_cause_e trap_cause_q, trap_cause_d;
  word_t       trap_pc_q, trap_pc_d;

  logic imem_req_q, ex_en_q, dmem_req_q, dmem_we_q, rf_we_q, trap_q;

  logic tmo_load, tmo_clear, tmo_count, tmo_expired;

  // One timer serves both wait states; it restarts on every state change.
  assign tmo_load  = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q);
  assign tmo_clear = (state_d != state_q) && !tmo_load;
  assign tmo_count = (state_q == ST_FETCH) || (state_q == ST_MEM);

  rv32_bus_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (tmo_clear),
    .load_i     (tmo_load),
    .count_en_i (tmo_count),
    .expired_o  (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    ctrl_d       = ctrl_q;
    br_taken_d   = br_taken_q;
    br_target_d  = br_target_q;
    trap_cause_d = trap_cause_q;
    trap_pc_d    = trap_pc_q;

    unique case (state_q)
      ST_RESET: state_d = ST_FETCH;

      ST_FETCH: begin
        // An ack in the expiring cycle still completes the fetch.
        if (bus.imem_ack_i) begin
          instr_d = bus.imem_rdata_i;
          state_d = ST_DECODE;
        end else if (tmo_expired) begin
          trap_cause_d = CAUSE_INSTR_ACCESS;
          state_d      = ST_TRAP;
        end
      end

      ST_DECODE: begin
        ctrl_d.mem_w  = mem_w_i;
        ctrl_d.reg_w  = reg_w_i;
        ctrl_d.is_lsu = is_lsu_i;
        if (illegal_i) begin
          trap_cause_d = CAUSE_ILLEGAL_INSTR;
          state_d      = ST_TRAP;
        end else if (ebreak_i) begin
          trap_cause_d = CAUSE_BREAKPOINT;
          state_d      = ST_TRAP;
        end else if (ecall_i) begin
          trap_cause_d = CAUSE_ECALL_M;
          state_d      = ST_TRAP;
        end else begin
          state_d = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        br_taken_d  = branch_taken_i;
        br_target_d = branch_target_i;
        if (branch_taken_i && is_misaligned(branch_target_i)) begin
          trap_cause_d = CAUSE_INSTR_MISALIGNED;
          state_d      = ST_TRAP;
        end else begin
          state_d = ctrl_q.is_lsu ? ST_MEM : ST_WB;
        end
      end

      ST_MEM: begin
        if (bus.dmem_ack_i) begin
          state_d = ST_WB;
        end else if (tmo_expired) begin
          trap_cause_d = ctrl_q.mem_w ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
          state_d      = ST_TRAP;
        end
      end

      ST_WB: begin
        pc_d    = br_taken_q ? br_target_q : next_pc(pc_q);
        state_d = ST_FETCH;
      end

      ST_TRAP: begin
        pc_d    = TRAP_VECTOR;
        state_d = ST_FETCH;
      end

      default: state_d = ST_RESET;
    endcase

    // The faulting PC is captured on entry so it is visible with the trap pulse.
    if (state_d == ST_TRAP) begin
      trap_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RESET;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      ctrl_q       <= '0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
      trap_cause_q <= CAUSE_INSTR_MISALIGNED;
      trap_pc_q    <= '0;
      imem_req_q   <= 1'b0;
      ex_en_q      <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      rf_we_q      <= 1'b0;
      trap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      ctrl_q       <= ctrl_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
      trap_cause_q <= trap_cause_d;
      trap_pc_q    <= trap_pc_d;
      // Strobes are decoded from the next state so they line up with state_q.
      imem_req_q   <= (state_d == ST_FETCH);
      ex_en_q      <= (state_d == ST_EXECUTE);
      dmem_req_q   <= (state_d == ST_MEM);
      dmem_we_q    <= (state_d == ST_MEM) && ctrl_d.mem_w;
      rf_we_q      <= (state_d == ST_WB) && ctrl_d.reg_w;
      trap_q       <= (state_d == ST_TRAP);
    end
  end

  assign bus.imem_req_o  = imem_req_q;
  assign bus.imem_addr_o = pc_q;
  assign bus.dmem_req_o  = dmem_req_q;
  assign bus.dmem_we_o   = dmem_we_q;
  assign instr_o         = instr_q;
  assign ex_en_o         = ex_en_q;
  assign rf_we_o         = rf_we_q;
  assign pc_o            = pc_q;
  assign trap_o          = trap_q;
  assign trap_cause_o    = trap_cause_q;
  assign trap_pc_o       = trap_pc_q;

endmodule
